// File: rtl/press_conditioner.sv
// Two-button press conditioner: synchronize, debounce and edge-detect
// each raw active-low key into a single-cycle press pulse.

module press_chan #(
    parameter int unsigned DEBOUNCE = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_n_i,
    input  logic freeze_i,
    output logic pulse_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;
    logic          pulse_d;

    // Counter restarts whenever s2 agrees with stable; a change is
    // only accepted after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = s2_q;
                pulse_d  = s2_q & ~freeze_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stable resets to pressed so a key held through reset stays silent.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            s1_q     <= ~key_n_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

module press_conditioner #(
    parameter int unsigned DEBOUNCE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic freeze,
    output logic L,
    output logic R
);

    press_chan #(.DEBOUNCE(DEBOUNCE)) u_left (
        .clk_i    (clk),
        .reset_i  (reset),
        .key_n_i  (key_l_n),
        .freeze_i (freeze),
        .pulse_o  (L)
    );

    press_chan #(.DEBOUNCE(DEBOUNCE)) u_right (
        .clk_i    (clk),
        .reset_i  (reset),
        .key_n_i  (key_r_n),
        .freeze_i (freeze),
        .pulse_o  (R)
    );

endmodule

// File: tb/tb_press_conditioner.sv
// Scoreboard bench for press_conditioner with DEBOUNCE = 4.
// Expected pulses are queued by stimulus and checked by a monitor.

module tb_press_conditioner;

    localparam int DB = 4;

    typedef struct {
        int   cyc;
        logic l;
        logic r;
    } exp_t;

    logic clk;
    logic reset;
    logic key_l_n;
    logic key_r_n;
    logic freeze;
    logic L;
    logic R;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;
    exp_t exp_q[$];

    press_conditioner #(.DEBOUNCE(DB)) dut (
        .clk     (clk),
        .reset   (reset),
        .key_l_n (key_l_n),
        .key_r_n (key_r_n),
        .freeze  (freeze),
        .L       (L),
        .R       (R)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse expected DEBOUNCE+1 edges after the first sampling edge.
    task automatic expect_press(input logic l, input logic r);
        exp_t e;
        e.cyc = cyc + 1 + DB + 1;
        e.l   = l;
        e.r   = r;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse: no pulse observed, expected at cyc %0d",
                         exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (L || R) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: L=%0b R=%0b at cyc %0d, expected none",
                             L, R, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_L", int'(L), int'(e.l));
                    chk("pulse_R", int'(R), int'(e.r));
                end
            end
        end
    end

    initial begin
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        freeze  = 1'b0;
        reset   = 1'b1;
        step(2);
        chk("reset_L", int'(L), 0);
        chk("reset_R", int'(R), 0);
        reset = 1'b0;
        step(10);

        // clean press
        key_l_n = 1'b0;
        expect_press(1'b1, 1'b0);
        step(20);
        key_l_n = 1'b1;
        step(10);

        // bounce, then steady press
        for (int i = 0; i < 8; i++) begin
            key_l_n = (i % 2 == 1);
            step(1);
        end
        key_l_n = 1'b1;
        step(10);
        key_l_n = 1'b0;
        expect_press(1'b1, 1'b0);
        step(20);
        key_l_n = 1'b1;
        step(10);

        // simultaneous
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        expect_press(1'b1, 1'b1);
        step(30);
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        step(10);

        // freeze
        freeze  = 1'b1;
        key_r_n = 1'b0;
        step(10);
        freeze = 1'b0;
        step(10);
        key_r_n = 1'b1;
        step(10);
        key_r_n = 1'b0;
        expect_press(1'b0, 1'b1);
        step(20);
        key_r_n = 1'b1;
        step(10);

        // reset while held
        key_l_n = 1'b0;
        reset   = 1'b1;
        step(1);
        chk("reset_held_L", int'(L), 0);
        chk("reset_held_R", int'(R), 0);
        reset = 1'b0;
        step(20);
        key_l_n = 1'b1;
        step(10);
        key_l_n = 1'b0;
        expect_press(1'b1, 1'b0);
        step(20);
        key_l_n = 1'b1;
        step(10);

        // reset mid-debounce
        key_l_n = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(20);
        key_l_n = 1'b1;
        step(10);

        chk("queue_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
